// File: rtl/inv_sub_state_seq.sv
// Multi-cycle AES inverse byte substitution over a 128-bit state.
// LANES inverse S-box lookups run per cycle, so one state takes
// G = 16/LANES BUSY cycles. Valid/ready handshakes on both sides.
// Byte k of the state lives at bits [8k:8k+7] (byte 0 is the MSB end).
module inv_sub_state_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [0:127] in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [0:127] out,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int         G        = 16 / LANES;
    localparam logic [3:0] LAST_GRP = 4'(G - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("inv_sub_state_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    logic [1:0]   state;
    logic [3:0]   cnt;
    logic [0:127] src;
    logic [0:127] res;

    logic [3:0]   lane_idx [LANES];
    logic [7:0]   lane_in  [LANES];
    logic [7:0]   lane_out [LANES];

    // GF(2^8) multiply modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // InvSubBytes: undo the affine map, then take the multiplicative
    // inverse as x^254 (which also maps 0 to 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] x;
        logic [7:0] sq;
        logic [7:0] r;
        x  = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Select the bytes of the current group and look them up.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_idx[j] = 4'(int'(cnt) * LANES + j);
            lane_in[j]  = src[{lane_idx[j], 3'b000} +: 8];
            lane_out[j] = inv_sbox(lane_in[j]);
        end
    end

    // Source register: loaded only when a state is accepted.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            src <= in;
        end
    end

    // Control FSM, group counter and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            res   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt   <= 4'd0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    for (int j = 0; j < LANES; j++) begin
                        res[{lane_idx[j], 3'b000} +: 8] <= lane_out[j];
                    end
                    if (cnt == LAST_GRP) begin
                        cnt   <= 4'd0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out       = res;

endmodule

// File: tb/tb_inv_sub_state_seq.sv
// Self-checking bench for inv_sub_state_seq. The reference S-boxes are
// built from exp/log tables over GF(2^8) (generator 3) plus the forward
// affine map; the inverse table is obtained by inverting the forward one.
module tb_inv_sub_state_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [0:127] din;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] dout;
    logic         out_valid;
    logic         out_ready;

    logic         aux_valid;
    logic         aux_ir  [4];
    logic         aux_ov  [4];
    logic [0:127] aux_out [4];

    int passed = 0;
    int total  = 0;

    logic [7:0] sbox [256];
    logic [7:0] isb  [256];

    always #5 clk = ~clk;

    inv_sub_state_seq #(.LANES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (dout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    for (genvar k = 0; k < 4; k++) begin : g_aux
        localparam int AL = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 8 : 16;
        inv_sub_state_seq #(.LANES(AL)) u_aux (
            .clk       (clk),
            .rst_n     (rst_n),
            .in        (din),
            .in_valid  (aux_valid),
            .in_ready  (aux_ir[k]),
            .out       (aux_out[k]),
            .out_valid (aux_ov[k]),
            .out_ready (out_ready)
        );
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    task automatic build_tables;
        logic [7:0] ex [256];
        int         lg [256];
        logic [7:0] e;
        logic [7:0] iv;
        e = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex[i]  = e;
            lg[e]  = i;
            e = e ^ ({e[6:0], 1'b0} ^ (e[7] ? 8'h1B : 8'h00));
        end
        for (int x = 0; x < 256; x++) begin
            iv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
            sbox[x] = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isb[sbox[x]] = 8'(x);
    endtask

    function automatic logic [0:127] sub_state(input logic [0:127] s, input bit inv);
        logic [0:127] r;
        for (int k = 0; k < 16; k++)
            r[8*k +: 8] = inv ? isb[s[8*k +: 8]] : sbox[s[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [0:127] rnd128;
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present d until accepted; returns just after the accepting edge.
    task automatic send(input logic [0:127] d);
        int n;
        in_valid = 1'b1;
        din      = d;
        n        = 0;
        while (!in_ready && n < 50) begin
            step;
            n++;
        end
        chk("accept", 128'(in_ready), 128'(1));
        step;
        in_valid = 1'b0;
        din      = rnd128();
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step;
            lat++;
        end
    endtask

    initial begin
        int           lat;
        int           n;
        bit           done;
        int           al   [4] = '{1, 2, 8, 16};
        bit           seen [4];
        int           alat [4];
        logic [0:127] aout [4];
        logic [0:127] d;
        logic [0:127] held;
        logic [0:127] orig;
        logic [0:127] bo;
        logic [0:127] bo_exp;

        build_tables();

        // Reset with in_valid asserted
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        aux_valid = 1'b1;
        out_ready = 1'b1;
        din       = rnd128();
        step;
        step;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out", dout, 128'h0);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        aux_valid = 1'b0;
        step;
        chk("rst_no_capture", 128'({in_ready, out_valid}), 128'(2'b10));

        // Uniform 0x63 pattern
        send({16{8'h63}});
        wait_out(lat);
        chk("uni_latency", 128'(lat), 128'(4));
        chk("uni_data", dout, 128'h0);
        chk("uni_in_ready_low", 128'(in_ready), 128'(0));
        step;
        chk("uni_back_idle", 128'({in_ready, out_valid}), 128'(2'b10));

        // Byte order on the LANES=4 instance
        bo     = {8'h7C, {14{8'h00}}, 8'h16};
        bo_exp = {8'h01, {14{8'h52}}, 8'hFF};
        send(bo);
        wait_out(lat);
        chk("bo_latency", 128'(lat), 128'(4));
        chk("bo_data", dout, bo_exp);
        step;

        // Byte order on LANES = 1, 2, 8, 16
        din       = bo;
        aux_valid = 1'b1;
        step;
        aux_valid = 1'b0;
        din       = rnd128();
        for (int k = 0; k < 4; k++) begin
            seen[k] = 1'b0;
            alat[k] = 0;
            aout[k] = '0;
        end
        for (int c = 1; c <= 20; c++) begin
            step;
            for (int k = 0; k < 4; k++) begin
                if (!seen[k] && aux_ov[k]) begin
                    seen[k] = 1'b1;
                    alat[k] = c;
                    aout[k] = aux_out[k];
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bo_latency_L%0d", al[k]), 128'(alat[k]), 128'(16 / al[k]));
            chk($sformatf("bo_data_L%0d", al[k]), aout[k], bo_exp);
            chk($sformatf("bo_idle_L%0d", al[k]), 128'({aux_ir[k], aux_ov[k]}), 128'(2'b10));
        end

        // Backpressure in DONE
        out_ready = 1'b0;
        d = rnd128();
        send(d);
        wait_out(lat);
        held = dout;
        chk("bp_data", dout, sub_state(d, 1'b1));
        for (int i = 0; i < 10; i++) begin
            din      = rnd128();
            in_valid = 1'b1;
            step;
            chk("bp_hold", dout, held);
            chk("bp_state", 128'({in_ready, out_valid}), 128'(2'b01));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step;
        chk("bp_release", 128'({in_ready, out_valid}), 128'(2'b10));
        step;
        chk("bp_single", 128'({in_ready, out_valid}), 128'(2'b10));

        // Reset in the cycle group 2 would be written
        send(rnd128());
        step;
        step;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        chk("mid_rst_state", 128'({in_ready, out_valid}), 128'(2'b10));
        chk("mid_rst_out", dout, 128'h0);
        send({16{8'hED}});
        wait_out(lat);
        chk("mid_rst_latency", 128'(lat), 128'(4));
        chk("mid_rst_data", dout, {16{8'h53}});
        step;

        // Round trip through forward then inverse substitution
        for (int t = 0; t < 100; t++) begin
            orig = rnd128();
            send(sub_state(orig, 1'b0));
            n    = 0;
            done = 1'b0;
            while (!done && n < 100) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    chk("rt_data", dout, orig);
                    done = 1'b1;
                end
                step;
                n++;
            end
            chk("rt_done", 128'(done), 128'(1));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
